acc_datapath_p: RTL

Parametrised accumulator-CPU datapath, the next generation of the 8-bit single-accumulator datapath. It holds PC, IR, memory-address register, accumulator, register file, ALU/shifter, a carry flag, a hardware return-address stack and a ready/valid output port. Every register update is driven by strobes from the external control FSM. Program/data RAM is external with synchronous read.

---
 rtl/acc_datapath_p.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/acc_datapath_p.sv
`default_nettype none
// ============================================================================
// Module   : acc_datapath_p
// Brief    : Parametrised accumulator-CPU datapath (PC, IR, MR, A, RF, ALU,
//            shifter, carry, return stack, ready/valid output port).
// Revision : 1.0  initial release
// ============================================================================
module acc_datapath_p #(
    parameter int DW   = 8,
    parameter int AW   = 6,
    parameter int RN   = 8,
    parameter int OFFW = 3,
    parameter int SD   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ir_load,
    input  logic          mr_load,
    input  logic          pc_load,
    input  logic          a_load,
    input  logic          rf_wr,
    input  logic          mem_inst,
    input  logic          mem_wr,
    input  logic          push,
    input  logic          out_en,
    input  logic [2:0]    pc_sel,
    input  logic [2:0]    a_sel,
    input  logic [2:0]    alu_sel,
    input  logic [1:0]    shft_sel,
    input  logic [DW-1:0] in_ext,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic [DW-1:0] ir,
    output logic          a_eq0,
    output logic          a_pos,
    output logic          carry,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          stk_err,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int RIW = (RN > 1) ? $clog2(RN) : 1;
    localparam int SPW = $clog2(SD + 1);
    localparam int SIW = (SD > 1) ? $clog2(SD) : 1;

    localparam logic [SPW-1:0] c_sp_one  = SPW'(1);
    localparam logic [SPW-1:0] c_sp_full = SPW'(SD);
    localparam logic [AW-1:0]  c_pc_one  = AW'(1);
    localparam logic [DW:0]    c_one_ext = (DW+1)'(1);

    localparam logic [2:0] c_alu_pass = 3'd0;
    localparam logic [2:0] c_alu_and  = 3'd1;
    localparam logic [2:0] c_alu_or   = 3'd2;
    localparam logic [2:0] c_alu_add  = 3'd3;
    localparam logic [2:0] c_alu_sub  = 3'd4;
    localparam logic [2:0] c_alu_not  = 3'd5;
    localparam logic [2:0] c_alu_inc  = 3'd6;
    localparam logic [2:0] c_alu_dec  = 3'd7;

    logic [AW-1:0]  r_pc;
    logic [DW-1:0]  r_ir;
    logic [AW-1:0]  r_mr;
    logic [DW-1:0]  r_a;
    logic           r_carry;
    logic [DW-1:0]  r_out_data;
    logic           r_out_valid;
    logic           r_stk_err;
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_stk [SD];
    logic [DW-1:0]  r_rf  [RN];

    logic [DW-1:0]  w_r;
    logic [AW-1:0]  w_off;
    logic [AW-1:0]  w_pc_inc;
    logic [AW-1:0]  w_pc_next;
    logic [SPW-1:0] w_sp_m1;
    logic [AW-1:0]  w_stk_top;
    logic           w_stk_empty;
    logic           w_stk_full;
    logic           w_call;
    logic           w_ret;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_stk_fault;
    logic [DW:0]    w_add;
    logic [DW:0]    w_sub;
    logic [DW:0]    w_inc;
    logic [DW:0]    w_dec;
    logic [DW-1:0]  w_alu;
    logic           w_alu_c;
    logic           w_carry_upd;
    logic [DW-1:0]  w_shift;
    logic [DW-1:0]  w_a_next;
    logic           w_out_load;

    // Register-file read and stack bookkeeping
    always_comb begin
        w_r         = r_rf[r_ir[RIW-1:0]];
        w_off       = {{(AW-OFFW){1'b0}}, r_ir[OFFW-1:0]};
        w_pc_inc    = r_pc + c_pc_one;
        w_sp_m1     = r_sp - c_sp_one;
        w_stk_top   = r_stk[w_sp_m1[SIW-1:0]];
        w_stk_empty = (r_sp == '0);
        w_stk_full  = (r_sp == c_sp_full);
        w_call      = pc_load & push & ((pc_sel == 3'd1) | (pc_sel == 3'd2) | (pc_sel == 3'd3));
        w_ret       = pc_load & (pc_sel == 3'd4);
        w_do_push   = w_call & ~w_stk_full;
        w_do_pop    = w_ret & ~w_stk_empty;
        w_stk_fault = (w_call & w_stk_full) | (w_ret & w_stk_empty);
    end

    always_comb begin
        w_pc_next = r_pc;
        case (pc_sel)
            3'd0:    w_pc_next = w_pc_inc;
            3'd1:    w_pc_next = ram_rdata[AW-1:0];
            3'd2:    w_pc_next = r_pc - w_off;
            3'd3:    w_pc_next = r_pc + w_off;
            3'd4:    w_pc_next = w_stk_empty ? r_pc : w_stk_top;
            default: w_pc_next = r_pc;
        endcase
    end

    // ALU: the extra MSB of each arithmetic result is the carry / borrow
    always_comb begin
        w_add       = {1'b0, r_a} + {1'b0, w_r};
        w_sub       = {1'b0, r_a} - {1'b0, w_r};
        w_inc       = {1'b0, r_a} + c_one_ext;
        w_dec       = {1'b0, r_a} - c_one_ext;
        w_alu       = r_a;
        w_alu_c     = r_carry;
        case (alu_sel)
            c_alu_pass: w_alu = r_a;
            c_alu_and:  w_alu = r_a & w_r;
            c_alu_or:   w_alu = r_a | w_r;
            c_alu_add:  begin w_alu = w_add[DW-1:0]; w_alu_c = w_add[DW]; end
            c_alu_sub:  begin w_alu = w_sub[DW-1:0]; w_alu_c = w_sub[DW]; end
            c_alu_not:  w_alu = ~r_a;
            c_alu_inc:  begin w_alu = w_inc[DW-1:0]; w_alu_c = w_inc[DW]; end
            c_alu_dec:  begin w_alu = w_dec[DW-1:0]; w_alu_c = w_dec[DW]; end
            default:    w_alu = r_a;
        endcase
        w_carry_upd = a_load & (a_sel == 3'd0) &
                      ((alu_sel == c_alu_add) | (alu_sel == c_alu_sub) |
                       (alu_sel == c_alu_inc) | (alu_sel == c_alu_dec));
    end

    always_comb begin
        w_shift = w_alu;
        case (shft_sel)
            2'd0:    w_shift = w_alu;
            2'd1:    w_shift = {w_alu[DW-2:0], 1'b0};
            2'd2:    w_shift = {1'b0, w_alu[DW-1:1]};
            default: w_shift = {w_alu[0], w_alu[DW-1:1]};
        endcase
    end

    always_comb begin
        w_a_next = '0;
        case (a_sel)
            3'd0:    w_a_next = w_shift;
            3'd1:    w_a_next = w_r;
            3'd2:    w_a_next = in_ext;
            3'd3:    w_a_next = ram_rdata;
            3'd4:    w_a_next = r_ir;
            default: w_a_next = '0;
        endcase
        // A stalled producer (valid held, no ready) drops further out_en
        w_out_load = out_en & (~r_out_valid | out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_mr        <= '0;
            r_a         <= '0;
            r_carry     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_stk_err   <= 1'b0;
            r_sp        <= '0;
        end else begin
            if (ir_load)
                r_ir <= ram_rdata;
            if (mr_load)
                r_mr <= ram_rdata[AW-1:0];
            if (pc_load)
                r_pc <= w_pc_next;
            if (w_do_push)
                r_sp <= r_sp + c_sp_one;
            else if (w_do_pop)
                r_sp <= w_sp_m1;
            if (w_stk_fault)
                r_stk_err <= 1'b1;
            if (a_load)
                r_a <= w_a_next;
            if (w_carry_upd)
                r_carry <= w_alu_c;
            if (w_out_load) begin
                r_out_data  <= r_a;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; the stack pointer alone defines validity
    always_ff @(posedge clk) begin
        if (!reset && w_do_push)
            r_stk[r_sp[SIW-1:0]] <= w_pc_inc;
        if (!reset && rf_wr)
            r_rf[r_ir[RIW-1:0]] <= r_a;
    end

    assign ram_addr  = mem_inst ? r_mr : r_pc;
    assign ram_wdata = r_a;
    assign ram_we    = mem_wr;
    assign ir        = r_ir;
    assign a_eq0     = (r_a == '0);
    assign a_pos     = ~r_a[DW-1];
    assign carry     = r_carry;
    assign stk_empty = w_stk_empty;
    assign stk_full  = w_stk_full;
    assign stk_err   = r_stk_err;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
